// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
// Optional feature macro: FETCH_SINGLE_STEP_EN adds the STEP state.
package fetch_pkg;

  localparam int WORD_W          = 16;
  localparam int DEFAULT_TIMEOUT = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_ERROR = 3'd5
`ifdef FETCH_SINGLE_STEP_EN
    , S_STEP = 3'd6
`endif
  } fetch_state_e;

  // Busy covers every state in which an instruction is in flight or pending.
  function automatic logic is_busy(input fetch_state_e s);
    return (s != S_IDLE) && (s != S_ERROR);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts EXEC cycles without Done; flags when TIMEOUT is hit.
// timeout_o is asserted in the cycle whose edge would bring the count to TIMEOUT,
// so the FSM leaves EXEC exactly TIMEOUT cycles after entering it.
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority, otherwise count stalled cycles up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = en_i && (cnt_d == LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches 16-bit words from a synchronous ROM and issues them to
// the multicycle processor with a one-cycle Run pulse, waiting for Done.
// Optional feature macro: FETCH_SINGLE_STEP_EN (Step input, STEP state).
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = (2 ** ADDR_W) - 1,
  parameter bit WRAP      = 1'b1,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic              Step,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_q,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);

  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(LAST_ADDR);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic              halted_q, halted_d;
  logic              stop_pend_q, stop_pend_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              last_s, retire_s, stop_now_s, halt_s, wd_timeout_s;

  assign last_s     = (pc_q == LAST_C);
  assign retire_s   = (state_q == S_EXEC) && Done;
  assign halt_s     = retire_s && last_s && !WRAP;
  // A Stop arriving in the retiring cycle counts as pending.
  assign stop_now_s = stop_pend_q || Stop;

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .clr_i     (state_q == S_ISSUE),
    .en_i      ((state_q == S_EXEC) && !Done),
    .timeout_o (wd_timeout_s)
  );

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: state_d = S_EXEC;
      S_EXEC: begin
        if (Done) begin
          if (halt_s || stop_now_s) state_d = S_IDLE;
`ifdef FETCH_SINGLE_STEP_EN
          else                      state_d = S_STEP;
`else
          else                      state_d = S_FETCH;
`endif
        end else if (wd_timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_EXEC;
        end
      end
`ifdef FETCH_SINGLE_STEP_EN
      S_STEP: begin
        if (stop_now_s) state_d = S_IDLE;
        else if (Step)  state_d = S_FETCH;
        else            state_d = S_STEP;
      end
`endif
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they leave a register.
  always_comb begin
    run_d  = (state_d == S_ISSUE);
    busy_d = is_busy(state_d);
    err_d  = (state_d == S_ERROR);
  end

  // PC, instruction word, halt flag and pending-stop next values.
  always_comb begin
    pc_d = pc_q;
    if (retire_s) begin
      if (last_s) pc_d = '0;
      else        pc_d = pc_q + ADDR_W'(1);
    end else begin
      pc_d = pc_q;
    end

    if (state_q == S_LOAD) din_d = mem_q;
    else                   din_d = din_q;

    if ((state_q == S_IDLE) && Start) halted_d = 1'b0;
    else if (halt_s)                  halted_d = 1'b1;
    else                              halted_d = halted_q;

    if (state_d == S_IDLE)                    stop_pend_d = 1'b0;
    else if (is_busy(state_q) && Stop)        stop_pend_d = 1'b1;
    else                                      stop_pend_d = stop_pend_q;
  end

  // Datapath and output registers.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pc_q        <= '0;
      din_q       <= '0;
      halted_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      din_q       <= din_d;
      halted_q    <= halted_d;
      stop_pend_q <= stop_pend_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr = pc_q;
  assign DIN      = din_q;
  assign Run      = run_q;
  assign Busy     = busy_q;
  assign Halted   = halted_q;
  assign Error    = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed test of instr_fetch with a ROM, a processor model
// and a cycle-timeline reference model of the sequencer.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int AW     = 8;
  localparam int LAST_A = 3;
  localparam bit WRAP_A = 1'b0;
  localparam int TO     = 6;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Resetn, Start_a, Stop_a, Done_a, Start_b, Stop_b, Done_b;
  logic hang_a, spur_a, chk_en;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [15:0]   mem_q_a, mem_q_b, DIN_a, DIN_b;
  logic          Run_a, Busy_a, Halted_a, Error_a;
  logic          Run_b, Busy_b, Halted_b, Error_b;
  logic [15:0]   rom_a [0:255];
  logic [15:0]   rom_b [0:255];

  int n_pass = 0;
  int n_chk  = 0;

  instr_fetch #(.ADDR_W(AW), .LAST_ADDR(LAST_A), .WRAP(WRAP_A), .TIMEOUT(TO)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .Start(Start_a), .Stop(Stop_a),
`ifdef FETCH_SINGLE_STEP_EN
    .Step(1'b1),
`endif
    .mem_addr(mem_addr_a), .mem_q(mem_q_a), .DIN(DIN_a), .Run(Run_a), .Done(Done_a),
    .Busy(Busy_a), .Halted(Halted_a), .Error(Error_a));

  instr_fetch #(.ADDR_W(AW), .LAST_ADDR(1), .WRAP(1'b1), .TIMEOUT(TO)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .Start(Start_b), .Stop(Stop_b),
`ifdef FETCH_SINGLE_STEP_EN
    .Step(1'b1),
`endif
    .mem_addr(mem_addr_b), .mem_q(mem_q_b), .DIN(DIN_b), .Run(Run_b), .Done(Done_b),
    .Busy(Busy_b), .Halted(Halted_b), .Error(Error_b));

  // Synchronous ROMs.
  always @(posedge Clock) begin
    mem_q_a <= rom_a[mem_addr_a];
    mem_q_b <= rom_b[mem_addr_b];
  end

  // Processor A: add/sub finish in the 3rd step after load, mv/mvt in the 1st.
  int steps_a = 0;
  always @(posedge Clock) begin
    if (!Resetn)            steps_a <= 0;
    else if (Run_a)         steps_a <= (DIN_a[15:13] == 3'b010 || DIN_a[15:13] == 3'b011) ? 3 : 1;
    else if (steps_a > 1)   steps_a <= steps_a - 1;
    else if (Done_a)        steps_a <= 0;
  end
  assign Done_a = ((steps_a == 1) && !hang_a) || spur_a;

  // Processor B: every word is a one-step mv.
  logic run_b_q = 1'b0;
  always @(posedge Clock) run_b_q <= Resetn ? Run_b : 1'b0;
  assign Done_b = run_b_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference timeline for A: cd counts cycles down to the Run pulse (-1 = executing).
  int m_cd = -1, m_pc = 0, m_cnt = 0;
  bit m_busy = 0, m_err = 0, m_halted = 0, m_pend = 0, m_halt;
  logic [15:0] m_din = 16'h0000;
  always @(negedge Clock) begin
    if (chk_en) begin
      check("run",    Run_a,      (m_busy && m_cd == 0));
      check("din",    DIN_a,      m_din);
      check("addr",   mem_addr_a, m_pc);
      check("busy",   Busy_a,     m_busy);
      check("halted", Halted_a,   m_halted);
      check("error",  Error_a,    m_err);
    end
    if (!Resetn) begin
      m_cd = -1; m_pc = 0; m_cnt = 0; m_busy = 0; m_err = 0; m_halted = 0; m_pend = 0;
      m_din = 16'h0000;
    end else if (!m_err) begin
      if (!m_busy) begin
        if (Start_a) begin m_busy = 1; m_halted = 0; m_cd = 2; end
      end else begin
        if (Stop_a) m_pend = 1;
        if (m_cd > 0) begin
          if (m_cd == 1) m_din = rom_a[m_pc];
          m_cd--;
        end else if (m_cd == 0) begin
          m_cd = -1; m_cnt = 0;
        end else if (Done_a) begin
          m_halt = 0;
          if (m_pc == LAST_A) begin m_pc = 0; m_halt = !WRAP_A; end
          else m_pc++;
          if (m_halt) m_halted = 1;
          if (m_halt || m_pend) begin m_busy = 0; m_pend = 0; end
          else m_cd = 2;
        end else begin
          m_cnt++;
          if (m_cnt == TO) begin m_err = 1; m_busy = 0; end
        end
      end
    end
  end

  // Capture B's first four issues.
  logic [AW-1:0] addr_b [0:3];
  logic [15:0]   din_b  [0:3];
  int nb = 0;
  always @(negedge Clock) begin
    if (chk_en && Run_b && nb < 4) begin
      addr_b[nb] <= mem_addr_b;
      din_b[nb]  <= DIN_b;
      nb <= nb + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  task automatic wait_run(output int n);
    n = 0;
    do begin tick(1); n++; end while (!Run_a && n < 40);
    check("wait_run", Run_a, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int n, runs;
  initial begin
    for (int i = 0; i < 256; i++) begin rom_a[i] = 16'h1000; rom_b[i] = 16'h1000; end
    rom_a[0] = 16'h1005; rom_a[1] = 16'h4201; rom_a[2] = 16'h1007; rom_a[3] = 16'h3A0F;
    rom_b[0] = 16'h1001; rom_b[1] = 16'h1002;
    Resetn = 1'b0; Start_a = 1'b0; Stop_a = 1'b0; Start_b = 1'b0; Stop_b = 1'b0;
    hang_a = 1'b0; spur_a = 1'b0; chk_en = 1'b0;
    tick(3);
    chk_en = 1'b1;
    check("rst_addr", mem_addr_a, 8'h00);
    check("rst_run",  Run_a,  1'b0);
    check("rst_busy", Busy_a, 1'b0);
    check("rst_din",  DIN_a,  16'h0000);
    check("rst_err",  Error_a, 1'b0);
    Resetn = 1'b1;
    tick(1);

    // Start pulse, then mv / add / mv / mvt through a WRAP=0 halt.
    Start_a = 1'b1; Start_b = 1'b1;
    tick(1);
    Start_a = 1'b0; Start_b = 1'b0;
    wait_run(n);
    check("start_to_run", n + 1, 3);
    check("din_w0", DIN_a, 16'h1005);
    tick(2);
    check("addr_after_done", mem_addr_a, 8'h01);
    wait_run(n);
    check("gap_mv", n + 2, 4);
    check("din_w1", DIN_a, 16'h4201);
    wait_run(n);
    check("gap_add", n, 6);
    check("din_w2", DIN_a, 16'h1007);
    wait_run(n);
    check("gap_mv2", n, 4);
    check("din_w3", DIN_a, 16'h3A0F);
    tick(2);
    check("halted", Halted_a, 1'b1);
    check("halt_busy", Busy_a, 1'b0);
    check("halt_pc", mem_addr_a, 8'h00);
    spur_a = 1'b1; tick(1); spur_a = 1'b0; tick(4);
    check("spur_done_pc", mem_addr_a, 8'h00);

    // B wraps 0,1,0,1 without halting.
    for (int i = 0; i < 4; i++) begin
      check("b_addr", addr_b[i], (i % 2));
      check("b_din",  din_b[i],  (i % 2 == 0) ? 16'h1001 : 16'h1002);
    end
    check("b_halted", Halted_b, 1'b0);
    check("b_busy",   Busy_b,   1'b1);

    // Restart from 0, Stop during ISSUE of word 2.
    Start_a = 1'b1; tick(1); Start_a = 1'b0;
    check("restart_halted", Halted_a, 1'b0);
    wait_run(n); check("re_din_w0", DIN_a, 16'h1005);
    wait_run(n); check("re_din_w1", DIN_a, 16'h4201);
    wait_run(n); check("re_din_w2", DIN_a, 16'h1007);
    Stop_a = 1'b1; tick(1); Stop_a = 1'b0; tick(1);
    check("stop_busy", Busy_a, 1'b0);
    check("stop_pc", mem_addr_a, 8'h03);
    runs = 0;
    for (int i = 0; i < 10; i++) begin tick(1); if (Run_a) runs++; end
    check("stop_no_run", runs, 0);

    // Processor hangs on word 3: Error 6 cycles after EXEC entry.
    hang_a = 1'b1;
    Start_a = 1'b1; tick(1); Start_a = 1'b0;
    wait_run(n); check("hang_din", DIN_a, 16'h3A0F);
    tick(6);
    check("wd_not_yet", Error_a, 1'b0);
    tick(1);
    check("wd_error", Error_a, 1'b1);
    check("wd_busy", Busy_a, 1'b0);
    tick(4);
    check("wd_sticky", Error_a, 1'b1);
    Resetn = 1'b0; tick(1);
    check("rst2_err", Error_a, 1'b0);
    check("rst2_pc", mem_addr_a, 8'h00);
    Resetn = 1'b1; hang_a = 1'b0; tick(1);

    // Start and Stop together in IDLE: Start wins, Stop not latched.
    Start_a = 1'b1; Stop_a = 1'b1; tick(1); Start_a = 1'b0; Stop_a = 1'b0;
    wait_run(n); check("ss_din_w0", DIN_a, 16'h1005);
    wait_run(n); check("ss_gap", n, 4);
    check("ss_din_w1", DIN_a, 16'h4201);
    tick(10);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer placed directly upstream of the 16-bit multicycle processor. Reads 16-bit instruction words from a synchronous ROM at a program counter, presents each word on the processor's DIN with a one-cycle Run pulse, waits for the processor's Done, then advances. Provides program start/stop control, end-of-program wrap or halt, and a Done watchdog that flags a hung processor.

## Interface
- ADDR_W, 8: ROM address width; PC width.
- LAST_ADDR, 2**ADDR_W-1: address of the final program word.
- WRAP, 1: 1 = PC wraps LAST_ADDR→0 and continues; 0 = halt after LAST_ADDR retires.
- TIMEOUT, 6: maximum EXEC cycles allowed without Done.

- Clock  in  1  rising-edge clock.
- Resetn  in  1  synchronous, active-low reset.
- Start  in  1  begin fetching from the current PC; sampled only in IDLE.
- Stop  in  1  request halt; takes effect at the next instruction boundary.
- mem_addr  out  ADDR_W  ROM address; always equals PC.
- mem_q  in  16  ROM data, valid one cycle after mem_addr.
- DIN  out  16  instruction word to processor (registered).
- Run  out  1  one-cycle issue strobe to processor.
- Done  in  1  processor completion, combinational from processor, high in its final step.
- Busy  out  1  high in every state except IDLE and ERROR.
- Halted  out  1  high after a WRAP=0 end-of-program halt; cleared by Start.
- Error  out  1  sticky watchdog flag.

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, EXEC, ERROR (plus STEP under the macro).
- IDLE: Run=0. Start=1 → FETCH, Halted←0.
- FETCH: ROM addressed with PC → LOAD.
- LOAD: DIN←mem_q → ISSUE.
- ISSUE: Run=1 for exactly this cycle; processor is in its instruction-load step → EXEC; watchdog cleared.
- EXEC: Run=0, DIN held. On Done=1: instruction retires at this edge, and:
  - PC≠LAST_ADDR: PC←PC+1.
  - PC=LAST_ADDR: WRAP=1 → PC←0; WRAP=0 → PC←0, Halted←1, next state IDLE.
  - Otherwise next state is IDLE if a Stop is pending, else FETCH.
- Stop: latched into a pending flag whenever Busy; never aborts an instruction; the flag clears on entering IDLE. Stop in IDLE is ignored. Start and Stop together in IDLE: Start wins; Stop is not latched.
- Watchdog: counts EXEC cycles with Done=0. When the count reaches TIMEOUT → ERROR. ERROR: Run=0, Busy=0, Error=1. Only Resetn exits ERROR.
- Done outside EXEC is ignored.
- PC arithmetic: unsigned ADDR_W bits; wrap uses an explicit compare with LAST_ADDR, not natural overflow.

## Timing
- Reset values: state IDLE, PC=0, DIN=0, Run=0, Busy=0, Halted=0, Error=0, Stop-pending=0, watchdog=0.
- Reset mid-instruction returns everything to reset values at the next edge. The processor shares Resetn.
- Start sampled at edge k → FETCH in cycle k+1, LOAD k+2, ISSUE (Run=1) k+3.
- Per-instruction cost is 3 cycles plus processor steps after load: mv/mvt = 4 cycles, add/sub = 6 cycles.
- Done in cycle c (EXEC) → FETCH in c+1 with the new mem_addr.

## Configuration
- FETCH_SINGLE_STEP_EN defined: adds input Step (1 bit) and state STEP. After each retirement (not halt or stop), the FSM enters STEP instead of FETCH. A Step=1 sample → FETCH. Stop in STEP → IDLE. Busy stays 1 in STEP.
- FETCH_SINGLE_STEP_EN undefined: no Step port, no STEP state; fetch is free-running.

## Structure
- Shared package fetch_pkg: state enumeration, WORD_W=16 constant, default TIMEOUT constant.
- One sub-module, fetch_watchdog. It holds the EXEC cycle counter with clear/enable inputs and a timeout output, parameterised by TIMEOUT.
- PC, DIN register and FSM live in instr_fetch.

## Test plan
- ROM[0]=mv r0,#5 (0x1005), Start pulse at cycle 2 → Run=1 at cycle 5 with DIN=0x1005; mem_addr=1 after Done.
- ROM[0..1]=add r1,r1 / mv, processor model giving Done in its 3rd step → Run pulses 6 cycles apart, then 4.
- WRAP=0, LAST_ADDR=3, four mv words → Halted=1, Busy=0, PC=0 after 4th Done; Start resumes at address 0 with Halted=0.
- WRAP=1, LAST_ADDR=1 → mem_addr sequence 0,1,0,1; no Halted.
- Stop asserted in ISSUE of word 2 → word 2 completes; IDLE with PC=3; Run never asserted again until Start.
- Processor model withholds Done → Error=1 exactly TIMEOUT=6 cycles after entering EXEC; Run stays 0; Resetn low → Error=0, PC=0.
